// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 membrane keypad emulator and its scanner.
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    GAP
  } kp_state_t;

  // Returns {row[1:0], col[1:0]} for a key code; the scanner decodes with the same map.
  function automatic logic [3:0] key_to_rc(input logic [3:0] key);
    logic [3:0] rc;
    rc = '0;
    case (key)
      4'h1: rc = {2'd0, 2'd0};
      4'h2: rc = {2'd0, 2'd1};
      4'h3: rc = {2'd0, 2'd2};
      4'hA: rc = {2'd0, 2'd3};
      4'h4: rc = {2'd1, 2'd0};
      4'h5: rc = {2'd1, 2'd1};
      4'h6: rc = {2'd1, 2'd2};
      4'hB: rc = {2'd1, 2'd3};
      4'h7: rc = {2'd2, 2'd0};
      4'h8: rc = {2'd2, 2'd1};
      4'h9: rc = {2'd2, 2'd2};
      4'hC: rc = {2'd2, 2'd3};
      4'h0: rc = {2'd3, 2'd0};
      4'hF: rc = {2'd3, 2'd1};
      4'hE: rc = {2'd3, 2'd2};
      4'hD: rc = {2'd3, 2'd3};
      default: rc = '0;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/keypad_emulator_bouncer.sv
// Contact bounce generator: BOUNCE_TOGGLES segments of BOUNCE_PERIOD cycles,
// level starting at init_level and inverting at each segment boundary.
module contact_bouncer #(
  parameter int unsigned BOUNCE_PERIOD  = 50_000,
  parameter int unsigned BOUNCE_TOGGLES = 6
) (
  input  logic clk_in,
  input  logic restart,
  input  logic start,
  input  logic init_level,
  output logic level,
  output logic busy
);

  logic [31:0] half_cnt;
  logic [31:0] seg_left;

  always_ff @(posedge clk_in) begin
    if (restart) begin
      level    <= 1'b0;
      busy     <= 1'b0;
      half_cnt <= '0;
      seg_left <= '0;
    end else if (start) begin
      level    <= init_level;
      busy     <= 1'b1;
      half_cnt <= BOUNCE_PERIOD - 1;
      seg_left <= BOUNCE_TOGGLES - 1;
    end else if (busy) begin
      if (half_cnt == '0) begin
        if (seg_left == '0) begin
          busy <= 1'b0;
        end else begin
          seg_left <= seg_left - 1;
          level    <= ~level;
          half_cnt <= BOUNCE_PERIOD - 1;
        end
      end else begin
        half_cnt <= half_cnt - 1;
      end
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 membrane keypad model: closes one latched key contact with make/break
// bounce, answering the scanner's active-low row strobes on the column lines.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned BOUNCE_PERIOD  = 50_000,
  parameter int unsigned BOUNCE_TOGGLES = 6,
  parameter int unsigned HOLD_CYCLES    = 20_000_000,
  parameter int unsigned GAP_CYCLES     = 10_000_000
) (
  input  logic       clk_in,
  input  logic       restart,
  input  logic       press_req,
  input  logic [3:0] press_key,
  output logic       press_ready,
  output logic       press_done,
  input  logic [3:0] keyb_row,
  output logic [3:0] keyb_col,
  output logic       pressed
);

  localparam int unsigned BOUNCE_LEN = BOUNCE_TOGGLES * BOUNCE_PERIOD;

  kp_state_t   state, state_next;
  logic [31:0] phase, phase_next;
  logic [3:0]  key_q;
  logic        done_q, done_next;
  logic        key_load;
  logic        bnc_start, bnc_init, bnc_level, bnc_busy;
  logic        contact;
  logic [3:0]  rc;
  logic [1:0]  key_row, key_col;

  contact_bouncer #(
    .BOUNCE_PERIOD  (BOUNCE_PERIOD),
    .BOUNCE_TOGGLES (BOUNCE_TOGGLES)
  ) u_bouncer (
    .clk_in     (clk_in),
    .restart    (restart),
    .start      (bnc_start),
    .init_level (bnc_init),
    .level      (bnc_level),
    .busy       (bnc_busy)
  );

  always_ff @(posedge clk_in) begin
    if (restart) begin
      state  <= IDLE;
      phase  <= '0;
      key_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      phase  <= phase_next;
      done_q <= done_next;
      if (key_load) key_q <= press_key;
    end
  end

  // The phase counter alone times every state; the bouncer only shapes the level.
  always_comb begin
    state_next = state;
    phase_next = phase;
    done_next  = 1'b0;
    key_load   = 1'b0;
    bnc_start  = 1'b0;
    bnc_init   = 1'b0;
    case (state)
      IDLE: begin
        if (press_req) begin
          key_load = 1'b1;
          if (BOUNCE_TOGGLES != 0) begin
            state_next = BOUNCE_IN;
            phase_next = BOUNCE_LEN - 1;
            bnc_start  = 1'b1;
            bnc_init   = 1'b1;
          end else begin
            state_next = HOLD;
            phase_next = HOLD_CYCLES - 1;
          end
        end
      end
      BOUNCE_IN: begin
        if (phase == '0) begin
          state_next = HOLD;
          phase_next = HOLD_CYCLES - 1;
        end else begin
          phase_next = phase - 1;
        end
      end
      HOLD: begin
        if (phase == '0) begin
          if (BOUNCE_TOGGLES != 0) begin
            state_next = BOUNCE_OUT;
            phase_next = BOUNCE_LEN - 1;
            bnc_start  = 1'b1;
          end else begin
            state_next = GAP;
            phase_next = GAP_CYCLES - 1;
          end
        end else begin
          phase_next = phase - 1;
        end
      end
      BOUNCE_OUT: begin
        if (phase == '0) begin
          state_next = GAP;
          phase_next = GAP_CYCLES - 1;
        end else begin
          phase_next = phase - 1;
        end
      end
      GAP: begin
        if (phase == '0) begin
          state_next = IDLE;
          phase_next = '0;
          done_next  = 1'b1;
        end else begin
          phase_next = phase - 1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    contact = 1'b0;
    case (state)
      BOUNCE_IN, BOUNCE_OUT: contact = bnc_busy & bnc_level;
      HOLD:                  contact = 1'b1;
      default:               contact = 1'b0;
    endcase
  end

  assign rc      = key_to_rc(key_q);
  assign key_row = rc[3:2];
  assign key_col = rc[1:0];

  always_comb begin
    keyb_col = '1;
    if (contact && !keyb_row[key_row]) keyb_col[key_col] = 1'b0;
  end

  assign press_ready = (state == IDLE);
  assign press_done  = done_q;
  assign pressed     = contact;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: per-cycle expectations queued at stimulus time.
module tb_keypad_emulator;

  localparam int P = 4;
  localparam int T = 4;
  localparam int H = 20;
  localparam int G = 8;

  typedef struct {
    logic [3:0] col;
    logic       done;
    logic       ready;
    logic       pressed;
  } exp_t;

  logic       clk = 1'b0;
  logic       restart = 1'b1;
  logic       press_req = 1'b0;
  logic [3:0] press_key = 4'h0;
  logic [3:0] keyb_row = 4'hF;
  logic       press_ready, press_done, pressed;
  logic [3:0] keyb_col;

  logic       press_req2 = 1'b0;
  logic [3:0] press_key2 = 4'h0;
  logic [3:0] keyb_row2 = 4'hF;
  logic       press_ready2, press_done2, pressed2;
  logic [3:0] keyb_col2;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  int tb_row [16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
  int tb_col [16] = '{0, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 2, 1};

  always #5 clk = ~clk;

  keypad_emulator #(
    .BOUNCE_PERIOD (P),
    .BOUNCE_TOGGLES(T),
    .HOLD_CYCLES   (H),
    .GAP_CYCLES    (G)
  ) dut (
    .clk_in     (clk),
    .restart    (restart),
    .press_req  (press_req),
    .press_key  (press_key),
    .press_ready(press_ready),
    .press_done (press_done),
    .keyb_row   (keyb_row),
    .keyb_col   (keyb_col),
    .pressed    (pressed)
  );

  keypad_emulator #(
    .BOUNCE_PERIOD (P),
    .BOUNCE_TOGGLES(0),
    .HOLD_CYCLES   (H),
    .GAP_CYCLES    (G)
  ) dut_nb (
    .clk_in     (clk),
    .restart    (restart),
    .press_req  (press_req2),
    .press_key  (press_key2),
    .press_ready(press_ready2),
    .press_done (press_done2),
    .keyb_row   (keyb_row2),
    .keyb_col   (keyb_col2),
    .pressed    (pressed2)
  );

  function automatic bit exp_contact(input int k, input int p, input int b, input int h);
    if (k <= b) return ((k - 1) / p) % 2 == 0;
    else if (k <= b + h) return 1'b1;
    else if (k <= 2 * b + h) return ((k - b - h - 1) / p) % 2 == 1;
    else return 1'b0;
  endfunction

  function automatic logic [3:0] rot_row(input int k);
    logic [3:0] r;
    r = 4'hF;
    r[k % 4] = 1'b0;
    return r;
  endfunction

  task automatic push_idle(input int n);
    exp_t e;
    e.col = 4'hF; e.done = 1'b0; e.ready = 1'b1; e.pressed = 1'b0;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  // Expectations for cycles 1..L+1 after an accept edge.
  task automatic push_seq(input logic [3:0] key, input logic [3:0] row, input bit rotate,
                          input int t);
    int b, l;
    b = t * P;
    l = 2 * b + H + G;
    for (int k = 1; k <= l + 1; k++) begin
      exp_t e;
      bit c;
      logic [3:0] r;
      r = rotate ? rot_row(k) : row;
      c = exp_contact(k, P, b, H);
      e.col = 4'hF;
      if (c && !r[tb_row[key]]) e.col[tb_col[key]] = 1'b0;
      e.pressed = c;
      e.ready = (k == l + 1);
      e.done = (k == l + 1);
      q.push_back(e);
    end
  endtask

  task automatic test_reset;
    restart = 1'b1;
    repeat (3) @(posedge clk);
    #1 restart = 1'b0;
    #1;
    checks++;
    if ({keyb_col, press_done, press_ready, pressed} !== {4'hF, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_main: col=%h done=%b ready=%b pressed=%b expected col=f done=0 ready=1 pressed=0",
               keyb_col, press_done, press_ready, pressed);
    end
    checks++;
    if ({keyb_col2, press_done2, press_ready2, pressed2} !== {4'hF, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_nobounce: col=%h done=%b ready=%b pressed=%b expected col=f done=0 ready=1 pressed=0",
               keyb_col2, press_done2, press_ready2, pressed2);
    end
  endtask

  task automatic test_idle;
    exp_t e;
    keyb_row = 4'b1110;
    push_idle(100);
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #2;
      checks++;
      if (q.size() == 0) begin errors++; $display("FAIL idle: queue empty at cycle %0d", k); end
      else begin
        e = q.pop_front();
        if ({keyb_col, press_done, press_ready, pressed} !== {e.col, e.done, e.ready, e.pressed}) begin
          errors++;
          $display("FAIL idle cycle %0d: col=%h done=%b ready=%b expected col=%h done=%b ready=%b",
                   k, keyb_col, press_done, press_ready, e.col, e.done, e.ready);
        end
      end
    end
  endtask

  task automatic test_single_press;
    exp_t e;
    #1;
    keyb_row = 4'b1101;
    press_key = 4'h5;
    press_req = 1'b1;
    push_seq(4'h5, 4'b1101, 1'b0, T);
    push_idle(2);
    @(posedge clk);
    for (int k = 1; k <= 63; k++) begin
      #1 press_req = 1'b0;
      #1;
      checks++;
      if (q.size() == 0) begin errors++; $display("FAIL single: queue empty at cycle %0d", k); end
      else begin
        e = q.pop_front();
        if ({keyb_col, press_done, press_ready, pressed} !== {e.col, e.done, e.ready, e.pressed}) begin
          errors++;
          $display("FAIL single cycle %0d: col=%h done=%b ready=%b pressed=%b expected col=%h done=%b ready=%b pressed=%b",
                   k, keyb_col, press_done, press_ready, pressed, e.col, e.done, e.ready, e.pressed);
        end
      end
      @(posedge clk);
    end
  endtask

  task automatic test_row_scan;
    exp_t e;
    #1;
    keyb_row = rot_row(0);
    press_key = 4'hD;
    press_req = 1'b1;
    push_seq(4'hD, 4'hF, 1'b1, T);
    @(posedge clk);
    for (int k = 1; k <= 61; k++) begin
      #1 press_req = 1'b0;
      keyb_row = rot_row(k);
      if (k == 25) press_key = 4'h1;
      #1;
      checks++;
      if (q.size() == 0) begin errors++; $display("FAIL scan: queue empty at cycle %0d", k); end
      else begin
        e = q.pop_front();
        if ({keyb_col, press_done, press_ready, pressed} !== {e.col, e.done, e.ready, e.pressed}) begin
          errors++;
          $display("FAIL scan cycle %0d row=%b: col=%h done=%b pressed=%b expected col=%h done=%b pressed=%b",
                   k, keyb_row, keyb_col, press_done, pressed, e.col, e.done, e.pressed);
        end
      end
      @(posedge clk);
    end
  endtask

  task automatic test_restart;
    exp_t e;
    #1;
    keyb_row = 4'b1101;
    press_key = 4'h6;
    press_req = 1'b1;
    push_seq(4'h6, 4'b1101, 1'b0, T);
    while (q.size() > 25) void'(q.pop_back());
    push_idle(70);
    @(posedge clk);
    for (int k = 1; k <= 95; k++) begin
      #1 press_req = 1'b0;
      #1;
      checks++;
      if (q.size() == 0) begin errors++; $display("FAIL restart: queue empty at cycle %0d", k); end
      else begin
        e = q.pop_front();
        if ({keyb_col, press_done, press_ready, pressed} !== {e.col, e.done, e.ready, e.pressed}) begin
          errors++;
          $display("FAIL restart cycle %0d: col=%h done=%b ready=%b pressed=%b expected col=%h done=%b ready=%b pressed=%b",
                   k, keyb_col, press_done, press_ready, pressed, e.col, e.done, e.ready, e.pressed);
        end
      end
      restart = (k == 25);
      @(posedge clk);
    end
    // Same-edge restart and request: restart must win.
    #1;
    restart = 1'b1;
    press_req = 1'b1;
    push_idle(6);
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      #1 restart = 1'b0;
      press_req = 1'b0;
      #1;
      checks++;
      if (q.size() == 0) begin errors++; $display("FAIL restart_prio: queue empty at cycle %0d", k); end
      else begin
        e = q.pop_front();
        if ({keyb_col, press_done, press_ready, pressed} !== {e.col, e.done, e.ready, e.pressed}) begin
          errors++;
          $display("FAIL restart_prio cycle %0d: col=%h ready=%b pressed=%b expected col=%h ready=%b pressed=%b",
                   k, keyb_col, press_ready, pressed, e.col, e.ready, e.pressed);
        end
      end
      @(posedge clk);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    #1;
    keyb_row = 4'b0110;
    press_key = 4'hA;
    press_req = 1'b1;
    push_seq(4'hA, 4'b0110, 1'b0, T);
    push_seq(4'h0, 4'b0110, 1'b0, T);
    push_idle(1);
    @(posedge clk);
    for (int k = 1; k <= 123; k++) begin
      #1;
      if (k == 2) press_key = 4'h0;
      if (k == 62) press_req = 1'b0;
      #1;
      checks++;
      if (q.size() == 0) begin errors++; $display("FAIL b2b: queue empty at cycle %0d", k); end
      else begin
        e = q.pop_front();
        if ({keyb_col, press_done, press_ready, pressed} !== {e.col, e.done, e.ready, e.pressed}) begin
          errors++;
          $display("FAIL b2b cycle %0d: col=%h done=%b ready=%b pressed=%b expected col=%h done=%b ready=%b pressed=%b",
                   k, keyb_col, press_done, press_ready, pressed, e.col, e.done, e.ready, e.pressed);
        end
      end
      @(posedge clk);
    end
  endtask

  task automatic test_no_bounce;
    exp_t e;
    #1;
    keyb_row2 = 4'b1110;
    press_key2 = 4'h3;
    press_req2 = 1'b1;
    push_seq(4'h3, 4'b1110, 1'b0, 0);
    push_idle(1);
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      #1 press_req2 = 1'b0;
      #1;
      checks++;
      if (q.size() == 0) begin errors++; $display("FAIL nobounce: queue empty at cycle %0d", k); end
      else begin
        e = q.pop_front();
        if ({keyb_col2, press_done2, press_ready2, pressed2} !== {e.col, e.done, e.ready, e.pressed}) begin
          errors++;
          $display("FAIL nobounce cycle %0d: col=%h done=%b ready=%b pressed=%b expected col=%h done=%b ready=%b pressed=%b",
                   k, keyb_col2, press_done2, press_ready2, pressed2, e.col, e.done, e.ready, e.pressed);
        end
      end
      @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_press();
    test_row_scan();
    test_restart();
    test_back_to_back();
    test_no_bounce();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
